// File: rtl/ysyx_22041412_axi_pkg.sv
// Shared definitions for the AXI read/write master arbiter.
package ysyx_22041412_axi_pkg;

    // Per-channel arbiter state: waiting for a request, or holding a grant for one burst.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Arbitration policies selectable through the ARB_MODE parameter.
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Next master index after idx, wrapping n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ysyx_22041412_rr_grant.sv
// Combinational grant picker: returns a one-hot grant for the first requester
// found when scanning upward from ptr (round-robin) or from index 0 (fixed).
module ysyx_22041412_rr_grant
    import ysyx_22041412_axi_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int PW      = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [PW-1:0]      ptr,
    input  logic               mode,
    output logic [NUM_MST-1:0] gnt
);

    int   base;
    int   idx;
    logic found;

    // Scan all masters once starting at the base index; first hit wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        base  = mode ? int'(ptr) : 0;
        for (int i = 0; i < NUM_MST; i++) begin
            idx = base + i;
            if (idx >= NUM_MST) begin
                idx = idx - NUM_MST;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_22041412_axi_mux_arb.sv
// N-to-1 AXI-lite-style request multiplexer with independent read and write
// arbiters. Each channel grants one master for a whole burst (until the
// downstream side returns ready together with last), then idles one cycle.
//
// Handshake: a beat transfers on every cycle where the channel is BUSY and the
// downstream ready is high; that ready (and last) is routed only to the granted
// master. The burst ends on ready && last. Upstream valid is only inspected in
// IDLE to pick a winner; while BUSY the grant is frozen.
module ysyx_22041412_axi_mux_arb
    import ysyx_22041412_axi_pkg::*;
#(
    parameter int NUM_MST        = 2,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int ARB_MODE       = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    // upstream read requests
    input  logic [NUM_MST-1:0]                m_r_valid,
    input  logic [NUM_MST*AXI_ADDR_WIDTH-1:0] m_r_addr,
    input  logic [NUM_MST*8-1:0]              m_r_len,
    input  logic [NUM_MST*8-1:0]              m_r_size,
    output logic [NUM_MST-1:0]                m_r_ready,
    output logic [NUM_MST-1:0]                m_r_last,
    output logic [AXI_DATA_WIDTH-1:0]         m_r_data,
    // upstream write requests
    input  logic [NUM_MST-1:0]                m_w_valid,
    input  logic [NUM_MST*AXI_ADDR_WIDTH-1:0] m_w_addr,
    input  logic [NUM_MST*AXI_DATA_WIDTH-1:0] m_w_data,
    input  logic [NUM_MST*8-1:0]              m_w_len,
    input  logic [NUM_MST*8-1:0]              m_w_size,
    output logic [NUM_MST-1:0]                m_w_ready,
    output logic [NUM_MST-1:0]                m_w_last,
    // downstream read port
    output logic                              r_valid_i,
    output logic [AXI_ADDR_WIDTH-1:0]         r_addr_i,
    output logic [7:0]                        r_len_i,
    output logic [7:0]                        r_size_i,
    input  logic                              r_ready_o,
    input  logic                              r_last_i,
    input  logic [AXI_DATA_WIDTH-1:0]         data_read_o,
    // downstream write port
    output logic                              w_valid_i,
    output logic [AXI_ADDR_WIDTH-1:0]         w_addr_i,
    output logic [AXI_DATA_WIDTH-1:0]         rw_w_data_i,
    output logic [7:0]                        w_len_i,
    output logic [7:0]                        w_size_i,
    input  logic                              w_ready_o,
    input  logic                              w_last_i,
    // FSM state observation
    output arb_state_e                        r_state_dbg,
    output arb_state_e                        w_state_dbg
);

    localparam int   AW      = AXI_ADDR_WIDTH;
    localparam int   DW      = AXI_DATA_WIDTH;
    localparam int   PW      = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam logic MODE_RR = (ARB_MODE == ARB_RR);

    arb_state_e         r_state, r_state_nxt;
    logic [NUM_MST-1:0] r_grant, r_grant_nxt, r_pick;
    logic [PW-1:0]      r_ptr, r_ptr_nxt, r_idx;

    arb_state_e         w_state, w_state_nxt;
    logic [NUM_MST-1:0] w_grant, w_grant_nxt, w_pick;
    logic [PW-1:0]      w_ptr, w_ptr_nxt, w_idx;

    assign r_state_dbg = r_state;
    assign w_state_dbg = w_state;

    ysyx_22041412_rr_grant #(.NUM_MST(NUM_MST), .PW(PW)) u_r_grant (
        .req  (m_r_valid),
        .ptr  (r_ptr),
        .mode (MODE_RR),
        .gnt  (r_pick)
    );

    ysyx_22041412_rr_grant #(.NUM_MST(NUM_MST), .PW(PW)) u_w_grant (
        .req  (m_w_valid),
        .ptr  (w_ptr),
        .mode (MODE_RR),
        .gnt  (w_pick)
    );

    // Encode the one-hot grants into indices for the pointer update.
    always_comb begin
        r_idx = '0;
        w_idx = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (r_grant[i]) r_idx = PW'(i);
            if (w_grant[i]) w_idx = PW'(i);
        end
    end

    // Read arbiter next-state: grant in IDLE, release on ready && last.
    always_comb begin
        r_state_nxt = r_state;
        r_grant_nxt = r_grant;
        r_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (|m_r_valid) begin
                    r_state_nxt = ST_BUSY;
                    r_grant_nxt = r_pick;
                end
            end
            ST_BUSY: begin
                if (r_ready_o && r_last_i) begin
                    r_state_nxt = ST_IDLE;
                    r_grant_nxt = '0;
                    r_ptr_nxt   = PW'(wrap_inc(int'(r_idx), NUM_MST));
                end
            end
            default: r_state_nxt = ST_IDLE;
        endcase
    end

    // Write arbiter next-state: same policy, independent of the read side.
    always_comb begin
        w_state_nxt = w_state;
        w_grant_nxt = w_grant;
        w_ptr_nxt   = w_ptr;
        case (w_state)
            ST_IDLE: begin
                if (|m_w_valid) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = w_pick;
                end
            end
            ST_BUSY: begin
                if (w_ready_o && w_last_i) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = PW'(wrap_inc(int'(w_idx), NUM_MST));
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, grant and pointer registers for both channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            w_state <= ST_IDLE;
            w_grant <= '0;
            w_ptr   <= '0;
        end else begin
            r_state <= r_state_nxt;
            r_grant <= r_grant_nxt;
            r_ptr   <= r_ptr_nxt;
            w_state <= w_state_nxt;
            w_grant <= w_grant_nxt;
            w_ptr   <= w_ptr_nxt;
        end
    end

    // Read datapath: forward the granted slice downstream and route ready/last back.
    always_comb begin
        r_valid_i = 1'b0;
        r_addr_i  = '0;
        r_len_i   = '0;
        r_size_i  = '0;
        m_r_ready = '0;
        m_r_last  = '0;
        m_r_data  = '0;
        if (r_state == ST_BUSY) begin
            m_r_data = data_read_o;
            for (int i = 0; i < NUM_MST; i++) begin
                if (r_grant[i]) begin
                    r_valid_i    = m_r_valid[i];
                    r_addr_i     = m_r_addr[i*AW +: AW];
                    r_len_i      = m_r_len[i*8 +: 8];
                    r_size_i     = m_r_size[i*8 +: 8];
                    m_r_ready[i] = r_ready_o;
                    m_r_last[i]  = r_last_i;
                end
            end
        end
    end

    // Write datapath: forward the granted slice downstream and route ready/last back.
    always_comb begin
        w_valid_i   = 1'b0;
        w_addr_i    = '0;
        rw_w_data_i = '0;
        w_len_i     = '0;
        w_size_i    = '0;
        m_w_ready   = '0;
        m_w_last    = '0;
        if (w_state == ST_BUSY) begin
            for (int i = 0; i < NUM_MST; i++) begin
                if (w_grant[i]) begin
                    w_valid_i    = m_w_valid[i];
                    w_addr_i     = m_w_addr[i*AW +: AW];
                    rw_w_data_i  = m_w_data[i*DW +: DW];
                    w_len_i      = m_w_len[i*8 +: 8];
                    w_size_i     = m_w_size[i*8 +: 8];
                    m_w_ready[i] = w_ready_o;
                    m_w_last[i]  = w_last_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_axi_mux_arb.sv
// Bench for the AXI master arbiter: a round-robin instance and a fixed-priority
// instance share all inputs; the bench acts as every master and as the slave.
module tb_ysyx_22041412_axi_mux_arb;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst;

    logic [N-1:0]    m_r_valid;
    logic [N*AW-1:0] m_r_addr;
    logic [N*8-1:0]  m_r_len, m_r_size;
    logic [N-1:0]    m_w_valid;
    logic [N*AW-1:0] m_w_addr;
    logic [N*DW-1:0] m_w_data;
    logic [N*8-1:0]  m_w_len, m_w_size;
    logic            r_ready_o, r_last_i, w_ready_o, w_last_i;
    logic [DW-1:0]   data_read_o;

    // round-robin instance outputs
    logic [N-1:0]  m_r_ready, m_r_last, m_w_ready, m_w_last;
    logic [DW-1:0] m_r_data, rw_w_data_i;
    logic          r_valid_i, w_valid_i, r_state_dbg, w_state_dbg;
    logic [AW-1:0] r_addr_i, w_addr_i;
    logic [7:0]    r_len_i, r_size_i, w_len_i, w_size_i;

    // fixed-priority instance outputs
    logic [N-1:0]  fx_m_r_ready, fx_m_r_last, fx_m_w_ready, fx_m_w_last;
    logic [DW-1:0] fx_m_r_data, fx_rw_w_data_i;
    logic          fx_r_valid_i, fx_w_valid_i, fx_r_state_dbg, fx_w_state_dbg;
    logic [AW-1:0] fx_r_addr_i, fx_w_addr_i;
    logic [7:0]    fx_r_len_i, fx_r_size_i, fx_w_len_i, fx_w_size_i;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [63:0] wexp_q[$];

    ysyx_22041412_axi_mux_arb #(.NUM_MST(N), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .ARB_MODE(1)) dut (
        .clk(clk), .rst(rst),
        .m_r_valid(m_r_valid), .m_r_addr(m_r_addr), .m_r_len(m_r_len), .m_r_size(m_r_size),
        .m_r_ready(m_r_ready), .m_r_last(m_r_last), .m_r_data(m_r_data),
        .m_w_valid(m_w_valid), .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_len(m_w_len),
        .m_w_size(m_w_size), .m_w_ready(m_w_ready), .m_w_last(m_w_last),
        .r_valid_i(r_valid_i), .r_addr_i(r_addr_i), .r_len_i(r_len_i), .r_size_i(r_size_i),
        .r_ready_o(r_ready_o), .r_last_i(r_last_i), .data_read_o(data_read_o),
        .w_valid_i(w_valid_i), .w_addr_i(w_addr_i), .rw_w_data_i(rw_w_data_i), .w_len_i(w_len_i),
        .w_size_i(w_size_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
        .r_state_dbg(r_state_dbg), .w_state_dbg(w_state_dbg)
    );

    ysyx_22041412_axi_mux_arb #(.NUM_MST(N), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .ARB_MODE(0)) dut_fx (
        .clk(clk), .rst(rst),
        .m_r_valid(m_r_valid), .m_r_addr(m_r_addr), .m_r_len(m_r_len), .m_r_size(m_r_size),
        .m_r_ready(fx_m_r_ready), .m_r_last(fx_m_r_last), .m_r_data(fx_m_r_data),
        .m_w_valid(m_w_valid), .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_len(m_w_len),
        .m_w_size(m_w_size), .m_w_ready(fx_m_w_ready), .m_w_last(fx_m_w_last),
        .r_valid_i(fx_r_valid_i), .r_addr_i(fx_r_addr_i), .r_len_i(fx_r_len_i), .r_size_i(fx_r_size_i),
        .r_ready_o(r_ready_o), .r_last_i(r_last_i), .data_read_o(data_read_o),
        .w_valid_i(fx_w_valid_i), .w_addr_i(fx_w_addr_i), .rw_w_data_i(fx_rw_w_data_i), .w_len_i(fx_w_len_i),
        .w_size_i(fx_w_size_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
        .r_state_dbg(fx_r_state_dbg), .w_state_dbg(fx_w_state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mst_addr(input int i);
        return BASE + 32'(i) * 32'h100;
    endfunction

    // driver tasks
    task automatic set_rd(input int i, input logic [31:0] addr, input logic [7:0] len, input logic [7:0] size);
        m_r_addr[i*AW +: AW] = addr;
        m_r_len[i*8 +: 8]    = len;
        m_r_size[i*8 +: 8]   = size;
    endtask

    task automatic set_wr(input int i, input logic [31:0] addr, input logic [63:0] data,
                          input logic [7:0] len, input logic [7:0] size);
        m_w_addr[i*AW +: AW] = addr;
        m_w_data[i*DW +: DW] = data;
        m_w_len[i*8 +: 8]    = len;
        m_w_size[i*8 +: 8]   = size;
    endtask

    task automatic go_idle();
        m_r_valid = '0;
        m_w_valid = '0;
        repeat (2) @(negedge clk);
        r_ready_o = 1'b0; r_last_i = 1'b0; w_ready_o = 1'b0; w_last_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_r_addr = '0; m_r_len = '0; m_r_size = '0;
        m_w_addr = '0; m_w_data = '0; m_w_len = '0; m_w_size = '0;
        m_r_valid = 3'b111; m_w_valid = 3'b111;
        r_ready_o = 1'b1; r_last_i = 1'b1; w_ready_o = 1'b1; w_last_i = 1'b1;
        data_read_o = 64'h1234_5678_9abc_def0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        total++;
        if ({r_valid_i, w_valid_i, r_state_dbg, w_state_dbg} !== 4'b0) begin
            $display("FAIL reset_ctrl got=%b want=0000", {r_valid_i, w_valid_i, r_state_dbg, w_state_dbg});
            bad++;
        end
        total++;
        if ({m_r_ready, m_r_last, m_w_ready, m_w_last} !== 12'b0) begin
            $display("FAIL reset_rdy_last got=%h want=0", {m_r_ready, m_r_last, m_w_ready, m_w_last});
            bad++;
        end
        total++;
        if (m_r_data !== 64'd0) begin
            $display("FAIL reset_rdata got=%h want=0", m_r_data);
            bad++;
        end
        total++;
        if ({r_addr_i, w_addr_i, rw_w_data_i} !== 128'd0) begin
            $display("FAIL reset_fields got=%h want=0", {r_addr_i, w_addr_i, rw_w_data_i});
            bad++;
        end
        m_r_valid = '0; m_w_valid = '0;
        r_ready_o = 1'b0; r_last_i = 1'b0; w_ready_o = 1'b0; w_last_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // All three masters hold len-0 reads; grants must rotate 0,1,2,0 with one idle gap each.
    task automatic test_rr_order();
        int gap, cycles, ei;
        logic [31:0] ea;
        logic [N-1:0] oh;
        for (int i = 0; i < N; i++) set_rd(i, mst_addr(i), 8'd0, 8'd3);
        exp_q.push_back(mst_addr(0)); exp_q.push_back(mst_addr(1));
        exp_q.push_back(mst_addr(2)); exp_q.push_back(mst_addr(0));
        r_ready_o = 1'b1; r_last_i = 1'b1;
        @(posedge clk); #1;
        m_r_valid = 3'b111;
        gap = 0; cycles = 0;
        while (exp_q.size() > 0 && cycles < 40) begin
            @(negedge clk); #1;
            cycles++;
            if (r_valid_i) begin
                ea = exp_q.pop_front();
                ei = int'((ea - BASE) >> 8);
                oh = '0; oh[ei] = 1'b1;
                total++;
                if (r_addr_i !== ea || m_r_ready !== oh || m_r_last !== oh) begin
                    $display("FAIL rr_grant addr=%h rdy=%b last=%b want addr=%h onehot=%b",
                             r_addr_i, m_r_ready, m_r_last, ea, oh);
                    bad++;
                end
                total++;
                if (gap !== 1) begin
                    $display("FAIL rr_gap got=%0d idle cycles want=1", gap);
                    bad++;
                end
                gap = 0;
                if (exp_q.size() == 0) m_r_valid = '0;
            end else begin
                gap++;
                total++;
                if (m_r_ready !== 3'b000) begin
                    $display("FAIL rr_idle_ready got=%b want=000", m_r_ready);
                    bad++;
                end
            end
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL rr_timeout pending=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        go_idle();
    endtask

    // Master 1 writes while master 0 reads: both downstream channels active together.
    task automatic test_concurrent();
        int cycles;
        logic seen;
        logic [31:0] ea;
        logic [63:0] ed;
        set_rd(0, 32'h8000_2000, 8'd0, 8'd3);
        set_wr(1, 32'h8000_1000, 64'hDEAD_BEEF, 8'd0, 8'd2);
        exp_q.push_back(32'h8000_2000);
        wexp_q.push_back(64'hDEAD_BEEF);
        data_read_o = 64'hCAFE_F00D_1234_5678;
        @(posedge clk); #1;
        m_r_valid = 3'b001; m_w_valid = 3'b010;
        cycles = 0; seen = 1'b0;
        while (!seen && cycles < 6) begin
            @(negedge clk);
            cycles++;
            if (r_valid_i || w_valid_i) begin
                seen = 1'b1;
                r_ready_o = 1'b1; r_last_i = 1'b1; w_ready_o = 1'b1; w_last_i = 1'b1;
                #1;
                ea = exp_q.pop_front();
                ed = wexp_q.pop_front();
                total++;
                if ({r_valid_i, w_valid_i} !== 2'b11) begin
                    $display("FAIL conc_valids got=%b want=11", {r_valid_i, w_valid_i});
                    bad++;
                end
                total++;
                if (r_addr_i !== ea || r_len_i !== 8'd0 || r_size_i !== 8'd3 || m_r_ready !== 3'b001) begin
                    $display("FAIL conc_read addr=%h len=%0d size=%0d rdy=%b want %h/0/3/001",
                             r_addr_i, r_len_i, r_size_i, m_r_ready, ea);
                    bad++;
                end
                total++;
                if (w_addr_i !== 32'h8000_1000 || rw_w_data_i !== ed || w_len_i !== 8'd0 || w_size_i !== 8'd2) begin
                    $display("FAIL conc_write addr=%h data=%h len=%0d size=%0d want 80001000/%h/0/2",
                             w_addr_i, rw_w_data_i, w_len_i, w_size_i, ed);
                    bad++;
                end
                total++;
                if (m_w_ready !== 3'b010 || m_w_last !== 3'b010) begin
                    $display("FAIL conc_wroute rdy=%b last=%b want 010/010", m_w_ready, m_w_last);
                    bad++;
                end
                total++;
                if (m_r_data !== 64'hCAFE_F00D_1234_5678) begin
                    $display("FAIL conc_rdata got=%h want=cafef00d12345678", m_r_data);
                    bad++;
                end
                m_r_valid = '0; m_w_valid = '0;
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL conc_timeout no downstream valid want=valid");
            exp_q.delete(); wexp_q.delete();
        end
        go_idle();
    endtask

    // Master 0 len-3 read; master 2 requests mid-burst and must wait for the burst to end.
    task automatic test_burst_hold();
        int cycles, beat, gap, rdy0, lst0, other, rdy2;
        logic raised;
        logic [31:0] ea;
        set_rd(0, 32'h8000_0000, 8'd3, 8'd3);
        set_rd(2, mst_addr(2), 8'd0, 8'd3);
        for (int k = 0; k < 4; k++) exp_q.push_back(32'h8000_0000);
        exp_q.push_back(mst_addr(2));
        @(posedge clk); #1;
        m_r_valid = 3'b001;
        cycles = 0; beat = 0; gap = 0; rdy0 = 0; lst0 = 0; other = 0; rdy2 = 0; raised = 1'b0;
        while (exp_q.size() > 0 && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (r_valid_i) begin
                r_ready_o = 1'b1;
                r_last_i  = (beat == int'(r_len_i));
            end else begin
                r_ready_o = 1'b0;
                r_last_i  = 1'b0;
            end
            #1;
            if (r_valid_i) begin
                ea = exp_q.pop_front();
                total++;
                if (r_addr_i !== ea) begin
                    $display("FAIL hold_addr got=%h want=%h", r_addr_i, ea);
                    bad++;
                end
                if (ea == 32'h8000_0000) begin
                    total++;
                    if (r_len_i !== 8'd3) begin
                        $display("FAIL hold_len got=%0d want=3", r_len_i);
                        bad++;
                    end
                    rdy0 += int'(m_r_ready[0]);
                    lst0 += int'(m_r_last[0]);
                    if (m_r_ready[2:1] != 2'b00 || m_r_last[2:1] != 2'b00) other++;
                    if (!raised) begin
                        m_r_valid[2] = 1'b1;
                        raised = 1'b1;
                    end
                end else begin
                    rdy2 += int'(m_r_ready[2]);
                    total++;
                    if (gap !== 1) begin
                        $display("FAIL hold_gap got=%0d want=1", gap);
                        bad++;
                    end
                end
                gap = 0;
                if (r_ready_o && r_last_i) begin
                    beat = 0;
                    if (ea == 32'h8000_0000) m_r_valid[0] = 1'b0;
                    else m_r_valid = '0;
                end else begin
                    beat++;
                end
            end else begin
                gap++;
            end
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL hold_timeout pending=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        total++;
        if (rdy0 !== 4 || lst0 !== 1) begin
            $display("FAIL hold_pulses ready0=%0d last0=%0d want 4/1", rdy0, lst0);
            bad++;
        end
        total++;
        if (other !== 0 || rdy2 !== 1) begin
            $display("FAIL hold_others leaks=%0d ready2=%0d want 0/1", other, rdy2);
            bad++;
        end
        go_idle();
    endtask

    // Reset on beat 2 of a len-3 burst abandons it; then master 1 alone is granted.
    task automatic test_reset_mid();
        int cycles, beat, gap;
        logic hit;
        logic [31:0] ea;
        set_rd(0, 32'h8000_3000, 8'd3, 8'd3);
        set_rd(1, mst_addr(1), 8'd0, 8'd3);
        data_read_o = 64'h0bad_0bad_0bad_0bad;
        @(posedge clk); #1;
        m_r_valid = 3'b001;
        cycles = 0; beat = 0; hit = 1'b0;
        while (!hit && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (r_valid_i) begin
                r_ready_o = 1'b1; r_last_i = 1'b0;
                if (beat == 2) begin
                    rst = 1'b1;
                    hit = 1'b1;
                end
                beat++;
            end
        end
        if (!hit) begin
            total++; bad++;
            $display("FAIL rmid_timeout beats=%0d want=3", beat);
        end
        @(negedge clk);
        r_last_i = 1'b1;
        #1;
        total++;
        if ({r_valid_i, m_r_ready, m_r_last, r_state_dbg} !== 8'b0 || m_r_data !== 64'd0) begin
            $display("FAIL rmid_outputs ctrl=%b data=%h want 0/0",
                     {r_valid_i, m_r_ready, m_r_last, r_state_dbg}, m_r_data);
            bad++;
        end
        m_r_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_r_valid = 3'b010;
        exp_q.push_back(mst_addr(1));
        cycles = 0; gap = 0;
        while (exp_q.size() > 0 && cycles < 10) begin
            @(negedge clk); #1;
            cycles++;
            if (r_valid_i) begin
                ea = exp_q.pop_front();
                total++;
                if (r_addr_i !== ea || m_r_ready !== 3'b010 || gap !== 1) begin
                    $display("FAIL rmid_regrant addr=%h rdy=%b gap=%0d want %h/010/1",
                             r_addr_i, m_r_ready, gap, ea);
                    bad++;
                end
                m_r_valid = '0;
            end else begin
                gap++;
            end
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL rmid_regrant_timeout pending=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        go_idle();
    endtask

    // Fixed-priority instance: masters 1 and 2 both request, master 1 must always win.
    task automatic test_fixed();
        int cycles, gap;
        logic [31:0] ea;
        for (int i = 0; i < N; i++) set_rd(i, mst_addr(i), 8'd0, 8'd3);
        for (int k = 0; k < 4; k++) exp_q.push_back(mst_addr(1));
        r_ready_o = 1'b1; r_last_i = 1'b1;
        @(posedge clk); #1;
        m_r_valid = 3'b110;
        cycles = 0; gap = 0;
        while (exp_q.size() > 0 && cycles < 40) begin
            @(negedge clk); #1;
            cycles++;
            if (fx_r_valid_i) begin
                ea = exp_q.pop_front();
                total++;
                if (fx_r_addr_i !== ea || fx_m_r_ready !== 3'b010 || fx_m_r_last !== 3'b010) begin
                    $display("FAIL fixed_grant addr=%h rdy=%b last=%b want %h/010/010",
                             fx_r_addr_i, fx_m_r_ready, fx_m_r_last, ea);
                    bad++;
                end
                total++;
                if (gap !== 1) begin
                    $display("FAIL fixed_gap got=%0d want=1", gap);
                    bad++;
                end
                gap = 0;
                if (exp_q.size() == 0) m_r_valid = '0;
            end else begin
                gap++;
            end
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL fixed_timeout pending=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_concurrent();
        test_burst_hold();
        test_reset_mid();
        test_fixed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
